// File: rtl/set_pattern_host.sv
// Self-test initiator for the SET candidate engine: replays a loaded pattern table
// through the en/busy/valid handshake and scores each returned candidate.
module set_pattern_host #(
  parameter int unsigned NUM_PAT   = 64,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned ERR_LIMIT = 10,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode_sel,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [23:0]       ld_central,
  input  logic [11:0]       ld_radius,
  input  logic [7:0]        ld_expected,
  output logic              set_en,
  output logic [23:0]       set_central,
  output logic [11:0]       set_radius,
  output logic [1:0]        set_mode,
  input  logic              set_busy,
  input  logic              set_valid,
  input  logic [7:0]        set_candidate,
  output logic              run_busy,
  output logic              done,
  output logic              pass,
  output logic [6:0]        err_cnt,
  output logic [ADDR_W-1:0] first_fail,
  output logic              first_fail_vld,
  output logic              timeout
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PAT - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [6:0]        ERR_MAX  = 7'd127;
  localparam logic [6:0]        ERR_LIM  = 7'(ERR_LIMIT);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic [23:0] cen_q [DEPTH];
  logic [11:0] rad_q [DEPTH];
  logic [7:0]  exp_q [DEPTH];

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [7:0]        cand_q, cand_d;
  logic              set_en_q, set_en_d;
  logic [23:0]       central_q, central_d;
  logic [11:0]       radius_q, radius_d;
  logic [1:0]        mode_q, mode_d;
  logic              run_busy_q, run_busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [6:0]        err_q, err_d;
  logic [ADDR_W-1:0] ff_q, ff_d;
  logic              ffv_q, ffv_d;
  logic              to_q, to_d;

  logic tbl_we_c;
  logic mismatch_c;

  // Table loads are locked out for the whole run so the replayed patterns stay fixed.
  assign tbl_we_c   = ld_we && !run_busy_q;
  assign mismatch_c = (cand_q != exp_q[idx_q]);

  always_ff @(posedge clk) begin
    if (tbl_we_c) begin
      cen_q[ld_addr] <= ld_central;
      rad_q[ld_addr] <= ld_radius;
      exp_q[ld_addr] <= ld_expected;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      tmr_q      <= '0;
      cand_q     <= '0;
      set_en_q   <= 1'b0;
      central_q  <= '0;
      radius_q   <= '0;
      mode_q     <= '0;
      run_busy_q <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      ff_q       <= '0;
      ffv_q      <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tmr_q      <= tmr_d;
      cand_q     <= cand_d;
      set_en_q   <= set_en_d;
      central_q  <= central_d;
      radius_q   <= radius_d;
      mode_q     <= mode_d;
      run_busy_q <= run_busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      ff_q       <= ff_d;
      ffv_q      <= ffv_d;
      to_q       <= to_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tmr_d      = tmr_q;
    cand_d     = cand_q;
    set_en_d   = 1'b0;
    central_d  = central_q;
    radius_d   = radius_q;
    mode_d     = mode_q;
    run_busy_d = run_busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    err_d      = err_q;
    ff_d       = ff_q;
    ffv_d      = ffv_q;
    to_d       = to_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d     = mode_sel;
          idx_d      = '0;
          err_d      = '0;
          ffv_d      = 1'b0;
          to_d       = 1'b0;
          pass_d     = 1'b0;
          run_busy_d = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // en is a single registered pulse; payload registers load on the same edge.
        if (!set_busy) begin
          set_en_d  = 1'b1;
          central_d = cen_q[idx_q];
          radius_d  = rad_q[idx_q];
          tmr_d     = '0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (set_valid) begin
          cand_d  = set_candidate;
          state_d = S_CHECK;
        end else if (tmr_q == TMR_LAST) begin
          to_d = 1'b1;
          if (!ffv_q) begin
            ff_d  = idx_q;
            ffv_d = 1'b1;
          end
          state_d = S_FINISH;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_CHECK: begin
        if (mismatch_c) begin
          err_d = (err_q == ERR_MAX) ? err_q : err_q + 7'd1;
          if (!ffv_q) begin
            ff_d  = idx_q;
            ffv_d = 1'b1;
          end
        end
        if ((ERR_LIMIT != 0) && (err_d == ERR_LIM)) begin
          state_d = S_FINISH;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_ISSUE;
        end
      end
      S_FINISH: begin
        done_d     = 1'b1;
        run_busy_d = 1'b0;
        pass_d     = (err_q == 7'd0) && !to_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign set_en         = set_en_q;
  assign set_central    = central_q;
  assign set_radius     = radius_q;
  assign set_mode       = mode_q;
  assign run_busy       = run_busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_q;
  assign first_fail     = ff_q;
  assign first_fail_vld = ffv_q;
  assign timeout        = to_q;

endmodule

// File: tb/tb_set_pattern_host.sv
// Bench for set_pattern_host: a behavioural SET stand-in answers each en, and a
// run-level reference predicts error count, first failure, timeout and patterns issued.
module tb_set_pattern_host;

  localparam int unsigned NP = 64;
  localparam int unsigned AW = 6;
  localparam int unsigned EL = 10;
  localparam int unsigned TO = 16;

  typedef struct packed {
    logic          done_seen;
    logic [6:0]    err;
    logic [AW-1:0] ff;
    logic          ffv;
    logic          to;
    logic          pass;
    logic          busy;
    logic [6:0]    iss;
  } res_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    mode_sel;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [23:0]   ld_central;
  logic [11:0]   ld_radius;
  logic [7:0]    ld_expected;
  logic          set_en;
  logic [23:0]   set_central;
  logic [11:0]   set_radius;
  logic [1:0]    set_mode;
  logic          set_busy;
  logic          set_valid;
  logic [7:0]    set_candidate;
  logic          run_busy;
  logic          done;
  logic          pass;
  logic [6:0]    err_cnt;
  logic [AW-1:0] first_fail;
  logic          first_fail_vld;
  logic          timeout;

  always #5 clk = ~clk;

  set_pattern_host #(.NUM_PAT(NP), .ADDR_W(AW), .ERR_LIMIT(EL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .mode_sel(mode_sel),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_central(ld_central),
    .ld_radius(ld_radius), .ld_expected(ld_expected),
    .set_en(set_en), .set_central(set_central), .set_radius(set_radius),
    .set_mode(set_mode), .set_busy(set_busy), .set_valid(set_valid),
    .set_candidate(set_candidate), .run_busy(run_busy), .done(done),
    .pass(pass), .err_cnt(err_cnt), .first_fail(first_fail),
    .first_fail_vld(first_fail_vld), .timeout(timeout)
  );

  logic [56:0] outs_c;
  assign outs_c = {set_en, set_central, set_radius, set_mode, run_busy, done, pass,
                   err_cnt, first_fail, first_fail_vld, timeout};

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [23:0] tc [NP];
  logic [11:0] tr [NP];
  logic [7:0]  te [NP];

  logic       force_busy = 1'b0;
  logic       inject = 1'b0;
  logic [7:0] inject_cand = 8'h00;
  int         withhold = -1;

  logic [23:0] q_c [$];
  logic [11:0] q_r [$];
  logic [1:0]  q_m [$];
  int          q_cyc [$];
  int          en_bad = 0;
  int          done_cnt = 0;
  logic        pending, busy_m, prev_en;
  logic [23:0] cap_c;
  logic [11:0] cap_r;
  logic [1:0]  cap_m;
  int          lat;

  // Candidate count of SET: bits of central selected by the mode against the doubled radius.
  function automatic logic [7:0] set_model(input logic [23:0] c, input logic [11:0] r,
                                           input logic [1:0] m);
    logic [23:0] rr, v;
    rr = {r, r};
    case (m)
      2'b00:   v = c ^ rr;
      2'b01:   v = c | rr;
      2'b10:   v = c & ~rr;
      default: v = c & rr;
    endcase
    return 8'($countones(v));
  endfunction

  // SET stand-in: busy from en until valid, valid 1..3 cycles after en, one withheld pattern.
  always begin
    @(negedge clk);
    #1;
    set_valid     = inject;
    set_candidate = inject_cand;
    if (!rst) begin
      pending = 1'b0;
      busy_m  = 1'b0;
      prev_en = 1'b0;
    end else begin
      if (start && !run_busy) begin
        q_c.delete(); q_r.delete(); q_m.delete(); q_cyc.delete();
        en_bad = 0;
        done_cnt = 0;
      end
      if (done) done_cnt++;
      if (set_en && (prev_en || set_busy)) en_bad++;
      if (pending) begin
        if (lat == 0) begin
          set_valid     = 1'b1;
          set_candidate = set_model(cap_c, cap_r, cap_m);
          pending       = 1'b0;
          busy_m        = 1'b0;
        end else begin
          lat--;
        end
      end
      if (set_en) begin
        q_c.push_back(set_central);
        q_r.push_back(set_radius);
        q_m.push_back(set_mode);
        q_cyc.push_back(cyc);
        cap_c   = set_central;
        cap_r   = set_radius;
        cap_m   = set_mode;
        pending = ((q_c.size() - 1) != withhold);
        busy_m  = pending;
        lat     = int'($urandom_range(0, 2));
      end
      prev_en = set_en;
    end
    set_busy = busy_m | force_busy;
  end

  // Run-level prediction straight from the table contents.
  function automatic res_t expect_run(input logic [1:0] m);
    res_t e;
    e = '0;
    e.done_seen = 1'b1;
    for (int i = 0; i < int'(NP); i++) begin
      e.iss = 7'(i + 1);
      if (i == withhold) begin
        e.to = 1'b1;
        if (!e.ffv) begin e.ff = AW'(i); e.ffv = 1'b1; end
        break;
      end
      if (te[i] != set_model(tc[i], tr[i], m)) begin
        e.err = e.err + 7'd1;
        if (!e.ffv) begin e.ff = AW'(i); e.ffv = 1'b1; end
        if (EL != 0 && int'(e.err) == int'(EL)) break;
      end
    end
    e.pass = (e.err == 7'd0) && !e.to;
    return e;
  endfunction

  function automatic int seq_bad(input logic [1:0] m);
    int b = 0;
    for (int i = 0; i < q_c.size(); i++)
      if (q_c[i] !== tc[i] || q_r[i] !== tr[i] || q_m[i] !== m) b++;
    return b;
  endfunction

  function automatic string fmt(input res_t r);
    return $sformatf("done=%0b err=%0d ff=%0d ffv=%0b to=%0b pass=%0b busy=%0b iss=%0d",
                     r.done_seen, r.err, r.ff, r.ffv, r.to, r.pass, r.busy, r.iss);
  endfunction

  task automatic write_entry(input int a, input logic [23:0] c, input logic [11:0] r,
                             input logic [7:0] e);
    @(negedge clk);
    ld_we = 1'b1; ld_addr = AW'(a); ld_central = c; ld_radius = r; ld_expected = e;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic load_table(input logic [1:0] m);
    for (int i = 0; i < int'(NP); i++) begin
      tc[i] = 24'($urandom);
      tr[i] = 12'($urandom);
      te[i] = set_model(tc[i], tr[i], m);
      write_entry(i, tc[i], tr[i], te[i]);
    end
  endtask

  task automatic pulse_start(input logic [1:0] m);
    @(negedge clk);
    start = 1'b1; mode_sel = m;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_run(output res_t o);
    logic ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    o.done_seen = ok;
    o.err  = err_cnt;
    o.ff   = first_fail_vld ? first_fail : '0;
    o.ffv  = first_fail_vld;
    o.to   = timeout;
    o.pass = pass;
    o.busy = run_busy;
    o.iss  = 7'(q_c.size());
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (outs_c !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", outs_c); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (outs_c !== '0) begin n_fail++; $display("FAIL idle_outputs: got %h want 0", outs_c); end
  endtask

  task automatic test_clean_run();
    res_t e, o;
    load_table(2'b00);
    e = expect_run(2'b00);
    pulse_start(2'b00);
    finish_run(o);
    n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL clean_run: got %s want %s", fmt(o), fmt(e)); end
    n_cmp++;
    if (seq_bad(2'b00) !== 0) begin n_fail++; $display("FAIL clean_seq: got %0d bad issues want 0", seq_bad(2'b00)); end
    @(negedge clk);
    n_cmp++;
    if ({done, done_cnt, en_bad} !== {1'b0, 32'd1, 32'd0}) begin
      n_fail++; $display("FAIL clean_pulses: got done=%0b done_cnt=%0d en_bad=%0d want 0/1/0", done, done_cnt, en_bad);
    end
  endtask

  task automatic test_two_errors();
    res_t e, o;
    load_table(2'b00);
    te[5]  = te[5]  ^ 8'($urandom_range(1, 255));
    te[17] = te[17] ^ 8'($urandom_range(1, 255));
    write_entry(5, tc[5], tr[5], te[5]);
    write_entry(17, tc[17], tr[17], te[17]);
    e = expect_run(2'b00);
    pulse_start(2'b00);
    finish_run(o);
    n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL two_errors: got %s want %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_err_limit();
    res_t e, o;
    logic [1:0] m;
    m = 2'($urandom_range(0, 3));
    load_table(m);
    for (int i = 3; i < 15; i++) begin
      te[i] = te[i] ^ 8'($urandom_range(1, 255));
      write_entry(i, tc[i], tr[i], te[i]);
    end
    e = expect_run(m);
    pulse_start(m);
    finish_run(o);
    n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL err_limit: got %s want %s", fmt(o), fmt(e)); end
    n_cmp++;
    if (seq_bad(m) !== 0) begin n_fail++; $display("FAIL err_limit_seq: got %0d bad issues want 0", seq_bad(m)); end
  endtask

  task automatic test_busy_hold();
    res_t e, o;
    logic [1:0] m;
    int en_seen = 0;
    m = 2'($urandom_range(0, 3));
    load_table(m);
    e = expect_run(m);
    force_busy = 1'b1;
    pulse_start(m);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (set_en) en_seen++;
    end
    n_cmp++;
    if (en_seen !== 0) begin n_fail++; $display("FAIL busy_hold_en: got %0d en pulses want 0", en_seen); end
    force_busy = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({set_en, set_central, set_radius, set_mode} !== {1'b1, tc[0], tr[0], m}) begin
      n_fail++;
      $display("FAIL busy_release_en: got en=%0b c=%h r=%h m=%0d want 1 c=%h r=%h m=%0d",
               set_en, set_central, set_radius, set_mode, tc[0], tr[0], m);
    end
    finish_run(o);
    n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL busy_hold_run: got %s want %s", fmt(o), fmt(e)); end
    n_cmp++;
    if (en_bad !== 0) begin n_fail++; $display("FAIL busy_hold_protocol: got %0d violations want 0", en_bad); end
  endtask

  task automatic test_timeout();
    res_t e, o;
    logic [1:0] m;
    logic seen = 1'b0;
    int t_cyc = 0;
    int dly;
    m = 2'($urandom_range(0, 3));
    load_table(m);
    withhold = 7;
    e = expect_run(m);
    pulse_start(m);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (timeout) begin seen = 1'b1; t_cyc = cyc; break; end
    end
    dly = (seen && q_cyc.size() >= 8) ? t_cyc - q_cyc[7] : -1;
    n_cmp++;
    if (dly !== int'(TO)) begin n_fail++; $display("FAIL timeout_latency: got %0d cycles want %0d", dly, TO); end
    finish_run(o);
    n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL timeout_run: got %s want %s", fmt(o), fmt(e)); end
    withhold = -1;
    @(negedge clk);
    inject_cand = te[7] ^ 8'h5a;
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({err_cnt, timeout, run_busy, pass, first_fail, done_cnt} !== {e.err, 1'b1, 1'b0, 1'b0, AW'(7), 32'd1}) begin
      n_fail++;
      $display("FAIL late_valid: got err=%0d to=%0b busy=%0b pass=%0b ff=%0d dones=%0d want %0d/1/0/0/7/1",
               err_cnt, timeout, run_busy, pass, first_fail, done_cnt, e.err);
    end
  endtask

  task automatic test_reset_midrun();
    res_t e, o;
    logic [1:0] m;
    int cnt = 0;
    int dn = 0;
    m = 2'($urandom_range(0, 3));
    load_table(m);
    te[2] = te[2] ^ 8'h01;
    write_entry(2, tc[2], tr[2], te[2]);
    pulse_start(m);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (set_en) cnt++;
      if (cnt == 31) break;
    end
    n_cmp++;
    if ({cnt, err_cnt} !== {32'd31, 7'd1}) begin
      n_fail++; $display("FAIL midrun_progress: got en=%0d err=%0d want 31/1", cnt, err_cnt);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (outs_c !== '0) begin n_fail++; $display("FAIL midrun_reset: got %h want 0", outs_c); end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done) dn++;
    end
    n_cmp++;
    if (dn !== 0) begin n_fail++; $display("FAIL midrun_no_done: got %0d pulses want 0", dn); end
    te[2] = te[2] ^ 8'h01;
    write_entry(2, tc[2], tr[2], te[2]);
    e = expect_run(m);
    pulse_start(m);
    finish_run(o);
    n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL rerun_after_reset: got %s want %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_start_with_load();
    res_t e, o;
    logic [1:0] m;
    int cnt = 0;
    m = 2'($urandom_range(0, 3));
    load_table(m);
    tc[0] = 24'($urandom);
    tr[0] = 12'($urandom);
    te[0] = set_model(tc[0], tr[0], m);
    e = expect_run(m);
    @(negedge clk);
    ld_we = 1'b1; ld_addr = '0; ld_central = tc[0]; ld_radius = tr[0]; ld_expected = te[0];
    start = 1'b1; mode_sel = m;
    @(negedge clk);
    ld_we = 1'b0; start = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (set_en) cnt++;
      if (cnt == 5) break;
    end
    // Mid-run load and restart attempts must not disturb the run.
    ld_we = 1'b1; ld_addr = AW'(63); ld_central = ~tc[63]; ld_radius = ~tr[63]; ld_expected = ~te[63];
    start = 1'b1; mode_sel = ~m;
    @(negedge clk);
    ld_we = 1'b0; start = 1'b0;
    finish_run(o);
    n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL start_with_load: got %s want %s", fmt(o), fmt(e)); end
    n_cmp++;
    if (seq_bad(m) !== 0) begin n_fail++; $display("FAIL start_with_load_seq: got %0d bad issues want 0", seq_bad(m)); end
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({done_cnt, run_busy} !== {32'd1, 1'b0}) begin
      n_fail++; $display("FAIL ignored_start: got dones=%0d busy=%0b want 1/0", done_cnt, run_busy);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; mode_sel = '0;
    ld_we = 1'b0; ld_addr = '0; ld_central = '0; ld_radius = '0; ld_expected = '0;
    test_reset();
    test_clean_run();
    test_two_errors();
    test_err_limit();
    test_busy_hold();
    test_timeout();
    test_reset_midrun();
    test_start_with_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
